parallel_mac_engine: RTL and testbench
======================================

Name: parallel_mac_engine

Overview:
Parametrised multi-lane multiply-accumulate engine for the pixel×weight dot products in the neuron datapath. It consumes NUM_INPUTS pixel/weight pairs LANES at a time through an internal pipelined multiplier bank. The lane products are reduced, accumulated and combined with a bias, then saturated and optionally ReLU-clamped. A start/busy/done handshake replaces free-running step counting, so the engine can be reused back-to-back by a layer controller.

Parameters:
NUM_INPUTS, 4, number of pixel/weight pairs per dot product (≥1)
LANES, 2, multipliers operating in parallel per beat (1..NUM_INPUTS)
PIXEL_WIDTH, 10, signed pixel, sfix10_En0
WEIGHT_WIDTH, 19, signed weight, sfix19_En18
OUTPUT_WIDTH, 26, signed result, sfix26_En18 (8 integer bits incl. sign)
MULT_LATENCY, 2, register stages inside each lane multiplier (≥1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  request; sampled only in IDLE
relu_en  input  1  clamp negative results to 0; captured with start
IN_PIXELS  input  NUM_INPUTS*PIXEL_WIDTH  pair i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]; captured with start
IN_WEIGHTS  input  NUM_INPUTS*WEIGHT_WIDTH  pair i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; captured with start
BIAS  input  OUTPUT_WIDTH  sfix26_En18 bias added once; captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; OUT/ovf valid from this cycle
OUT  output  OUTPUT_WIDTH  result, held until the next done
ovf  output  1  saturation occurred for the result in OUT

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, OUT=0, ovf=0, accumulator and pipeline valids cleared. Reset mid-operation aborts the job. No done is produced for it.
- States: IDLE → ISSUE → DRAIN → FINISH → IDLE.
- IDLE: when start=1 at edge T, capture inputs, BIAS and relu_en into operand registers and enter ISSUE. Clear the accumulator.
- ISSUE: B = ceil(NUM_INPUTS/LANES) beats, one per cycle, at edges T+1..T+B. Beat k feeds pairs k*LANES..k*LANES+LANES-1. Lanes with index ≥ NUM_INPUTS feed 0×0. After the last beat, enter DRAIN.
- Pipeline per beat: MULT_LATENCY product stages (signed PIXEL_WIDTH+WEIGHT_WIDTH = 29-bit, En18), then 1 lane-sum register, then accumulate.
- Accumulator width is OUTPUT_WIDTH+ceil(log2(NUM_INPUTS))+4 bits, signed, En18, with no intermediate saturation. The BIAS is sign-extended and preloaded at the first accumulate.
- DRAIN: wait until the last beat's accumulate completes, then enter FINISH.
- FINISH (1 cycle): the saturated/ReLU result is registered into OUT and ovf, and done=1.
- done rises exactly LAT = B + MULT_LATENCY + 3 edges after edge T. For the defaults, B=2 and LAT=7.
- Saturation: clamp to [−2^(OUTPUT_WIDTH−1), 2^(OUTPUT_WIDTH−1)−1]. Set ovf=1 if clamped, else 0.
- ReLU: applied after saturation. If relu_en=1 and the result is negative, OUT=0; ovf keeps the saturation flag.
- start while busy=1 is ignored, and input changes while busy have no effect.
- start=1 in the done cycle is accepted, because the state is IDLE on that edge. This gives back-to-back jobs every LAT+1 cycles.
- OUT/ovf hold their values between done pulses, including through the next job's busy period.
- busy and done are never high in the same cycle.

Test Plan:
1. Defaults; pixels {1,2,3,4}, all weights 0x20000 (0.5), BIAS=0, start pulse → done exactly 7 cycles later; OUT=0x140000 (5.0), ovf=0, busy high for cycles 1..6.
2. Pixel0=−3 (0x3FD), weight0=0x40000 (−1.0), other pairs 0, BIAS=0x040000 (1.0) → OUT=0x100000 (4.0).
3. All pixels 511, all weights 0x3FFFF, BIAS=0x1FFFFFF → OUT=0x1FFFFFF, ovf=1. Then all pixels −512, weights 0x1FFFF → OUT=0x2000000, ovf=1.
4. Result −2.0 (pixel0=−4, weight0=0.5): relu_en=0 → OUT=0x3F80000; relu_en=1 → OUT=0, ovf=0.
5. Second start asserted 3 cycles into a job → ignored, single done. Start asserted in the done cycle → second done 8 cycles after the first, with correct results for both jobs.
6. rst low for 1 cycle at cycle 4 of a job → OUT=0, busy=0, no done. Sweep NUM_INPUTS=5, LANES=2 (padding lane) and LANES=1, MULT_LATENCY=3: done at the LAT given by the formula, OUT matches the reference model.

Source files
------------

// File: rtl/parallel_mac_engine.sv
// Multi-lane multiply-accumulate engine: pixel x weight dot product plus bias,
// with saturation to the output format and optional ReLU, driven by start/busy/done.
module parallel_mac_engine #(
    parameter int NUM_INPUTS   = 4,
    parameter int LANES        = 2,
    parameter int PIXEL_WIDTH  = 10,
    parameter int WEIGHT_WIDTH = 19,
    parameter int OUTPUT_WIDTH = 26,
    parameter int MULT_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 relu_en,
    input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0]    IN_PIXELS,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]   IN_WEIGHTS,
    input  logic [OUTPUT_WIDTH-1:0]              BIAS,
    output logic                                 busy,
    output logic                                 done,
    output logic [OUTPUT_WIDTH-1:0]              OUT,
    output logic                                 ovf
);

    localparam int BEATS  = (NUM_INPUTS + LANES - 1) / LANES;
    localparam int SLOTS  = BEATS * LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH;
    localparam int ACC_W  = OUTPUT_WIDTH + $clog2(NUM_INPUTS) + 4;
    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX   = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN   = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

    state_t                          state_q, state_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic                            accept, issue;

    logic [SLOTS*PIXEL_WIDTH-1:0]    pix_pad;
    logic [SLOTS*WEIGHT_WIDTH-1:0]   wgt_pad;
    logic signed [PIXEL_WIDTH-1:0]   pix_q [SLOTS];
    logic signed [WEIGHT_WIDTH-1:0]  wgt_q [SLOTS];
    logic signed [OUTPUT_WIDTH-1:0]  bias_q;
    logic                            relu_q;

    logic signed [PIXEL_WIDTH-1:0]   lane_pix [LANES];
    logic signed [WEIGHT_WIDTH-1:0]  lane_wgt [LANES];
    logic signed [PROD_W-1:0]        prod_q [MULT_LATENCY][LANES];
    logic [MULT_LATENCY-1:0]         pv_q, pf_q, pl_q;

    logic signed [ACC_W-1:0]         sum_d, sum_q;
    logic                            sv_q, sf_q, sl_q;
    logic signed [ACC_W-1:0]         acc_q;
    logic                            acc_done_q;

    logic [ACC_W-OUTPUT_WIDTH:0]     acc_upper;
    logic                            clamp;
    logic [OUTPUT_WIDTH-1:0]         sat_val, res_val;
    logic [OUTPUT_WIDTH-1:0]         out_q;
    logic                            ovf_q, done_q;

    // Pad the operand buses to whole beats so the unused lanes multiply 0 x 0.
    assign pix_pad = (SLOTS*PIXEL_WIDTH)'(IN_PIXELS);
    assign wgt_pad = (SLOTS*WEIGHT_WIDTH)'(IN_WEIGHTS);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    beat_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (acc_done_q) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < SLOTS; i++) begin
                pix_q[i] <= pix_pad[i*PIXEL_WIDTH +: PIXEL_WIDTH];
                wgt_q[i] <= wgt_pad[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
            bias_q <= BIAS;
            relu_q <= relu_en;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_pix[l] = '0;
            lane_wgt[l] = '0;
        end
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    lane_pix[l] = pix_q[b*LANES + l];
                    lane_wgt[l] = wgt_q[b*LANES + l];
                end
            end
        end
    end

    // Product pipeline carries data only; the valid/first/last tags travel alongside it.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            prod_q[0][l] <= PROD_W'(lane_pix[l]) * PROD_W'(lane_wgt[l]);
            for (int s = 1; s < MULT_LATENCY; s++) begin
                prod_q[s][l] <= prod_q[s-1][l];
            end
        end
        sum_q <= sum_d;
    end

    always_comb begin
        sum_d = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_d = sum_d + ACC_W'(prod_q[MULT_LATENCY-1][l]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q       <= '0;
            pf_q       <= '0;
            pl_q       <= '0;
            sv_q       <= 1'b0;
            sf_q       <= 1'b0;
            sl_q       <= 1'b0;
            acc_q      <= '0;
            acc_done_q <= 1'b0;
        end else begin
            pv_q[0] <= issue;
            pf_q[0] <= issue && (beat_q == '0);
            pl_q[0] <= issue && (beat_q == LAST_BEAT);
            for (int s = 1; s < MULT_LATENCY; s++) begin
                pv_q[s] <= pv_q[s-1];
                pf_q[s] <= pf_q[s-1];
                pl_q[s] <= pl_q[s-1];
            end
            sv_q <= pv_q[MULT_LATENCY-1];
            sf_q <= pf_q[MULT_LATENCY-1];
            sl_q <= pl_q[MULT_LATENCY-1];
            if (accept) begin
                acc_q      <= '0;
                acc_done_q <= 1'b0;
            end else if (sv_q) begin
                // The first beat folds the sign-extended bias in instead of the cleared value.
                acc_q <= (sf_q ? ACC_W'(bias_q) : acc_q) + sum_q;
                if (sl_q) acc_done_q <= 1'b1;
            end
        end
    end

    // In range exactly when every bit above the output sign bit matches it.
    assign acc_upper = acc_q[ACC_W-1:OUTPUT_WIDTH-1];
    assign clamp     = !((&acc_upper) || (~|acc_upper));
    assign sat_val   = clamp ? (acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX) : acc_q[OUTPUT_WIDTH-1:0];
    assign res_val   = (relu_q && sat_val[OUTPUT_WIDTH-1]) ? '0 : sat_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_FINISH);
            if (state_q == S_FINISH) begin
                out_q <= res_val;
                ovf_q <= clamp;
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign OUT  = out_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_parallel_mac_engine.sv
// Bench for parallel_mac_engine: three configurations driven with shared directed
// vectors, checked every cycle against an arithmetic job-level model.
module tb_parallel_mac_engine;

    localparam int NDUT = 3;
    localparam int N_OF   [NDUT] = '{4, 5, 4};
    localparam int LAT_OF [NDUT] = '{7, 8, 10};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NDUT-1:0] start_v = '0;
    logic relu = 1'b0;
    logic signed [9:0]  pix [5];
    logic signed [18:0] wgt [5];
    logic signed [25:0] bias = '0;
    logic [49:0] pix_bus;
    logic [94:0] wgt_bus;

    logic        busy_v [NDUT];
    logic        done_v [NDUT];
    logic [25:0] out_v  [NDUT];
    logic        ovf_v  [NDUT];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pix_bus[i*10 +: 10] = pix[i];
            wgt_bus[i*19 +: 19] = wgt[i];
        end
    end

    parallel_mac_engine #(.NUM_INPUTS(4), .LANES(2), .MULT_LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .relu_en(relu),
        .IN_PIXELS(pix_bus[39:0]), .IN_WEIGHTS(wgt_bus[75:0]), .BIAS(bias),
        .busy(busy_v[0]), .done(done_v[0]), .OUT(out_v[0]), .ovf(ovf_v[0]));

    parallel_mac_engine #(.NUM_INPUTS(5), .LANES(2), .MULT_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .relu_en(relu),
        .IN_PIXELS(pix_bus), .IN_WEIGHTS(wgt_bus), .BIAS(bias),
        .busy(busy_v[1]), .done(done_v[1]), .OUT(out_v[1]), .ovf(ovf_v[1]));

    parallel_mac_engine #(.NUM_INPUTS(4), .LANES(1), .MULT_LATENCY(3)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .relu_en(relu),
        .IN_PIXELS(pix_bus[39:0]), .IN_WEIGHTS(wgt_bus[75:0]), .BIAS(bias),
        .busy(busy_v[2]), .done(done_v[2]), .OUT(out_v[2]), .ovf(ovf_v[2]));

    // ---------------- job-level model ----------------
    int          cyc = 0;
    logic        m_busy [NDUT] = '{default: 1'b0};
    logic        m_done [NDUT] = '{default: 1'b0};
    logic [25:0] m_out  [NDUT] = '{default: '0};
    logic        m_ovf  [NDUT] = '{default: 1'b0};
    logic [25:0] m_res  [NDUT];
    logic        m_rovf [NDUT];
    int          m_done_edge [NDUT];
    logic        m_was;

    function automatic void model_res(input int n, output logic [25:0] r, output logic o);
        longint s;
        s = longint'(bias);
        for (int i = 0; i < n; i++) s += longint'(pix[i]) * longint'(wgt[i]);
        o = 1'b0;
        if (s > 64'sd33554431) begin
            s = 64'sd33554431;
            o = 1'b1;
        end else if (s < -64'sd33554432) begin
            s = -64'sd33554432;
            o = 1'b1;
        end
        if (relu && s < 0) s = 0;
        r = s[25:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < NDUT; d++) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b0;
                m_out[d]  = '0;
                m_ovf[d]  = 1'b0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < NDUT; d++) begin
                m_was     = m_busy[d];
                m_done[d] = 1'b0;
                if (m_was && cyc == m_done_edge[d]) begin
                    m_done[d] = 1'b1;
                    m_busy[d] = 1'b0;
                    m_out[d]  = m_res[d];
                    m_ovf[d]  = m_rovf[d];
                end
                if (!m_was && start_v[d]) begin
                    model_res(N_OF[d], m_res[d], m_rovf[d]);
                    m_busy[d]      = 1'b1;
                    m_done_edge[d] = cyc + LAT_OF[d];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if ({busy_v[d], done_v[d], out_v[d], ovf_v[d]} !== {m_busy[d], m_done[d], m_out[d], m_ovf[d]}) begin
                n_err++;
                $display("FAIL cycle%0d dut%0d busy/done/out/ovf: got %b/%b/%h/%b want %b/%b/%h/%b",
                         cyc, d, busy_v[d], done_v[d], out_v[d], ovf_v[d],
                         m_busy[d], m_done[d], m_out[d], m_ovf[d]);
            end
        end
    end

    int n_done0 = 0;
    int last_done0 = 0;
    int prev_done0 = 0;
    always @(negedge clk) begin
        if (done_v[0]) begin
            n_done0++;
            prev_done0 = last_done0;
            last_done0 = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic set_all(input logic signed [9:0] p, input logic signed [18:0] w);
        for (int i = 0; i < 5; i++) begin
            pix[i] = p;
            wgt[i] = w;
        end
    endtask

    task automatic pulse_start(input logic [NDUT-1:0] m);
        @(posedge clk); #2 start_v = m;
        @(posedge clk); #2 start_v = '0;
    endtask

    task automatic wait_idle();
        repeat (12) @(posedge clk);
        #2;
    endtask

    int t_start;
    int nd;

    initial begin
        set_all('0, '0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        check_lit("reset_out", 32'(out_v[0]), 32'h0);
        check_lit("reset_busy", 32'(busy_v[0]), 32'h0);

        // 1: {1,2,3,4} x 0.5 -> 5.0
        set_all('0, 19'h20000);
        pix[0] = 10'd1; pix[1] = 10'd2; pix[2] = 10'd3; pix[3] = 10'd4;
        pulse_start('1);
        t_start = cyc;
        wait_idle();
        check_lit("t1_out", 32'(out_v[0]), 32'h140000);
        check_lit("t1_ovf", 32'(ovf_v[0]), 32'h0);
        check_lit("t1_lat", 32'(last_done0 - t_start), 32'd7);
        check_lit("t1_out_n5", 32'(out_v[1]), 32'h140000);
        check_lit("t1_out_l1", 32'(out_v[2]), 32'h140000);

        // 2: -3 x -1.0 + 1.0 -> 4.0
        set_all('0, '0);
        pix[0] = 10'h3FD; wgt[0] = 19'h40000; bias = 26'h040000;
        pulse_start('1);
        wait_idle();
        check_lit("t2_out", 32'(out_v[0]), 32'h100000);

        // 3: positive and negative saturation
        set_all(10'd511, 19'h3FFFF); bias = 26'h1FFFFFF;
        pulse_start('1);
        wait_idle();
        check_lit("t3_pos_out", 32'(out_v[0]), 32'h1FFFFFF);
        check_lit("t3_pos_ovf", 32'(ovf_v[0]), 32'h1);
        set_all(10'h200, 19'h1FFFF);
        pulse_start('1);
        wait_idle();
        check_lit("t3_neg_out", 32'(out_v[0]), 32'h2000000);
        check_lit("t3_neg_ovf", 32'(ovf_v[0]), 32'h1);

        // 4: -4 x 0.5 = -2.0 without and with ReLU
        set_all('0, '0);
        pix[0] = 10'h3FC; wgt[0] = 19'h20000; bias = '0; relu = 1'b0;
        pulse_start('1);
        wait_idle();
        check_lit("t4_norelu", 32'(out_v[0]), 32'h3F80000);
        relu = 1'b1;
        pulse_start('1);
        wait_idle();
        check_lit("t4_relu_out", 32'(out_v[0]), 32'h0);
        check_lit("t4_relu_ovf", 32'(ovf_v[0]), 32'h0);
        relu = 1'b0;

        // fifth pair only reaches the 5-input engine (padding lane)
        set_all('0, '0);
        pix[0] = 10'd2; wgt[0] = 19'h10000; pix[4] = 10'd7; wgt[4] = 19'h40000; bias = 26'h080000;
        pulse_start('1);
        wait_idle();
        check_lit("pad_n4", 32'(out_v[0]), 32'h0A0000);
        check_lit("pad_n5", 32'(out_v[1]), 32'h3EE0000);

        // 5a: start and input change mid-job are ignored
        set_all('0, 19'h20000);
        pix[0] = 10'd1; pix[1] = 10'd2; pix[2] = 10'd3; pix[3] = 10'd4; bias = '0;
        nd = n_done0;
        pulse_start('1);
        repeat (2) @(posedge clk);
        #2 start_v = '1; pix[0] = 10'd100;
        @(posedge clk); #2 start_v = '0;
        wait_idle();
        check_lit("t5_single_done", 32'(n_done0 - nd), 32'd1);
        check_lit("t5_out", 32'(out_v[0]), 32'h140000);

        // 5b: start in the done cycle is accepted
        set_all('0, '0);
        pix[0] = 10'h3FD; wgt[0] = 19'h40000; bias = 26'h040000;
        pulse_start(3'b001);
        repeat (7) @(posedge clk);
        #2;
        check_lit("b2b_done_high", 32'(done_v[0]), 32'h1);
        check_lit("b2b_first_out", 32'(out_v[0]), 32'h100000);
        set_all('0, '0);
        pix[0] = 10'h3FC; wgt[0] = 19'h20000; bias = '0;
        start_v = 3'b001;
        @(posedge clk); #2 start_v = '0;
        wait_idle();
        check_lit("b2b_second_out", 32'(out_v[0]), 32'h3F80000);
        check_lit("b2b_spacing", 32'(last_done0 - prev_done0), 32'd8);

        // 6: reset mid-job aborts without done
        set_all('0, 19'h20000);
        pix[0] = 10'd1; pix[1] = 10'd2; pix[2] = 10'd3; pix[3] = 10'd4;
        nd = n_done0;
        pulse_start('1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        check_lit("t6_out", 32'(out_v[0]), 32'h0);
        check_lit("t6_busy", 32'(busy_v[0]), 32'h0);
        wait_idle();
        check_lit("t6_no_done", 32'(n_done0 - nd), 32'd0);

        // recovery job after the abort
        pulse_start('1);
        wait_idle();
        check_lit("t6_recover", 32'(out_v[0]), 32'h140000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
